// File: rtl/exe_mem_skid_reg.sv
// Two-entry skid buffer used as the EXE->MEM pipeline register.
// in_ready comes from the occupancy flop, so a cache miss never reaches EXE combinationally.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wbEn,
    input  logic              in_memRead,
    input  logic              in_memWrite,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_valRm,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              mem_ready,
    output logic              out_valid,
    output logic              out_wbEn,
    output logic              out_memRead,
    output logic              out_memWrite,
    output logic [DATA_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    state_e             state_q, state_d;
    entry_t             head_q, head_d;
    entry_t             tail_q, tail_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    entry_t             in_entry;
    logic               push;
    logic               pop;

    assign in_entry = '{
        wb_en:     in_wbEn,
        mem_read:  in_memRead,
        mem_write: in_memWrite,
        address:   in_aluResult,
        data:      in_valRm,
        dest:      in_dest
    };

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && mem_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        stall_d = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    tail_d  = in_entry;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (out_valid && !mem_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: entry registers are cleared too, so out_* read zero after reset and no stale entry survives.
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end

    // Control bits are qualified by out_valid so a bubble never starts an access.
    assign out_wbEn     = head_q.wb_en     && out_valid;
    assign out_memRead  = head_q.mem_read  && out_valid;
    assign out_memWrite = head_q.mem_write && out_valid;
    assign out_address  = head_q.address;
    assign out_data     = head_q.data;
    assign out_dest     = head_q.dest;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg; a second instance with CNT_W=4 covers saturation.
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_wbEn;
    logic        in_memRead;
    logic        in_memWrite;
    logic [31:0] in_aluResult;
    logic [31:0] in_valRm;
    logic [3:0]  in_dest;
    logic        mem_ready;

    logic        in_ready;
    logic        out_valid;
    logic        out_wbEn;
    logic        out_memRead;
    logic        out_memWrite;
    logic [31:0] out_address;
    logic [31:0] out_data;
    logic [3:0]  out_dest;
    logic [15:0] stall_cycles;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_wbEn;
    logic        s_out_memRead;
    logic        s_out_memWrite;
    logic [31:0] s_out_address;
    logic [31:0] s_out_data;
    logic [3:0]  s_out_dest;
    logic [3:0]  s_stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_mem_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_wbEn(in_wbEn), .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_aluResult(in_aluResult), .in_valRm(in_valRm), .in_dest(in_dest),
        .mem_ready(mem_ready), .out_valid(out_valid), .out_wbEn(out_wbEn),
        .out_memRead(out_memRead), .out_memWrite(out_memWrite),
        .out_address(out_address), .out_data(out_data), .out_dest(out_dest),
        .stall_cycles(stall_cycles)
    );

    exe_mem_skid_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_wbEn(in_wbEn), .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_aluResult(in_aluResult), .in_valRm(in_valRm), .in_dest(in_dest),
        .mem_ready(mem_ready), .out_valid(s_out_valid), .out_wbEn(s_out_wbEn),
        .out_memRead(s_out_memRead), .out_memWrite(s_out_memWrite),
        .out_address(s_out_address), .out_data(s_out_data), .out_dest(s_out_dest),
        .stall_cycles(s_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
        in_valid     = v;
        in_wbEn      = wb;
        in_memRead   = rd;
        in_memWrite  = wr;
        in_aluResult = addr;
        in_valRm     = data;
        in_dest      = dest;
    endtask

    initial begin
        // Reset held for two cycles with in_valid high.
        rst       = 1'b0;
        mem_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 4'h7);
        tick();
        tick();
        check("rst_in_ready",  in_ready,     1);
        check("rst_out_valid", out_valid,    0);
        check("rst_wbEn",      out_wbEn,     0);
        check("rst_memRead",   out_memRead,  0);
        check("rst_memWrite",  out_memWrite, 0);
        check("rst_address",   out_address,  0);
        check("rst_data",      out_data,     0);
        check("rst_dest",      out_dest,     0);
        check("rst_stall",     stall_cycles, 0);

        // Bubble gating while EMPTY.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
        tick();
        check("bub_valid",    out_valid,    0);
        check("bub_memWrite", out_memWrite, 0);
        check("bub_memRead",  out_memRead,  0);
        check("bub_wbEn",     out_wbEn,     0);

        // Streaming at one per cycle.
        mem_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'h1);
        tick();
        check("str_a_addr",  out_address, 32'h400);
        check("str_a_valid", out_valid,   1);
        check("str_a_rdy",   in_ready,    1);
        check("str_a_wb",    out_wbEn,    1);
        check("str_a_dest",  out_dest,    4'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 4'h2);
        tick();
        check("str_b_addr", out_address, 32'h404);
        check("str_b_rdy",  in_ready,    1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h408, 32'h0, 4'h3);
        tick();
        check("str_c_addr", out_address, 32'h408);
        check("str_c_rdy",  in_ready,    1);
        in_valid = 1'b0;
        tick();
        check("str_drain_valid", out_valid,    0);
        check("str_stall",       stall_cycles, 0);

        // Miss stall: A (load) then B (store), memory not ready for 5 cycles.
        mem_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'h4);
        tick();
        check("miss_a_addr", out_address, 32'h400);
        check("miss_a_rd",   out_memRead, 1);
        check("miss_a_rdy",  in_ready,    1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h404, 32'hDEAD, 4'h5);
        tick();
        check("miss_full_rdy", in_ready,     0);
        check("miss_addr_1",   out_address,  32'h400);
        check("miss_stall_1",  stall_cycles, 1);
        // Offered while full; must be ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h999, 32'h999, 4'h9);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("miss_addr_hold", out_address, 32'h400);
            check("miss_rdy_low",   in_ready,    0);
        end
        check("miss_stall_5", stall_cycles, 5);
        mem_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        check("miss_b_addr",  out_address,  32'h404);
        check("miss_b_data",  out_data,     32'hDEAD);
        check("miss_b_wr",    out_memWrite, 1);
        check("miss_b_rd",    out_memRead,  0);
        check("miss_b_dest",  out_dest,     4'h5);
        check("miss_rdy_back", in_ready,    1);
        check("miss_stall_keep", stall_cycles, 5);
        tick();
        check("miss_empty", out_valid, 0);

        // Simultaneous push and pop at ONE.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 4'h6);
        tick();
        check("pp_a_addr", out_address, 32'h500);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h504, 32'h0, 4'h7);
        tick();
        check("pp_b_addr",  out_address, 32'h504);
        check("pp_b_valid", out_valid,   1);
        check("pp_b_rdy",   in_ready,    1);
        in_valid = 1'b0;
        tick();
        check("pp_empty", out_valid, 0);

        // Reset while FULL.
        mem_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 4'h8);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h604, 32'h0, 4'h9);
        tick();
        check("rf_full_rdy", in_ready,     0);
        check("rf_stall",    stall_cycles, 6);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rf_valid",   out_valid,    0);
        check("rf_rdy",     in_ready,     1);
        check("rf_addr",    out_address,  0);
        check("rf_stall0",  stall_cycles, 0);
        rst       = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("rf_after_1", out_valid, 0);
        tick();
        check("rf_after_2", out_valid, 0);

        // Counter saturation: 20 stall cycles.
        mem_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_small_15", s_stall_cycles, 4'hF);
        check("sat_wide_20",  stall_cycles,   20);
        tick();
        tick();
        tick();
        check("sat_small_hold", s_stall_cycles, 4'hF);
        check("sat_wide_23",    stall_cycles,   23);
        check("sat_addr_hold",  out_address,    32'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
